// File: rtl/cci_mpf_if_pkg.sv
// Shared CCI-MPF types: request/response channel structs, the in-flight read
// count type and the read-throttle error codes.
package cci_mpf_if_pkg;

  localparam int CCI_MPF_ADDR_W  = 42;
  localparam int CCI_MPF_MDATA_W = 16;
  localparam int CCI_MPF_DATA_W  = 64;

  localparam int CCI_MPF_DFLT_MAX_ACTIVE_READS = 128;
  localparam int CCI_MPF_RD_ACTIVE_CNT_W = $clog2(CCI_MPF_DFLT_MAX_ACTIVE_READS + 1);

  typedef struct packed {
    logic [CCI_MPF_ADDR_W-1:0]  addr;
    logic [CCI_MPF_MDATA_W-1:0] mdata;
  } t_cci_mpf_ReqMemHdr;

  typedef struct packed {
    logic                       rdValid;
    logic [CCI_MPF_MDATA_W-1:0] mdata;
    logic [CCI_MPF_DATA_W-1:0]  data;
  } t_cci_mpf_c0Rx;

  typedef struct packed {
    logic                      wrValid;
    t_cci_mpf_ReqMemHdr        hdr;
    logic [CCI_MPF_DATA_W-1:0] data;
  } t_cci_mpf_c1Tx;

  typedef struct packed {
    logic                       wrValid;
    logic [CCI_MPF_MDATA_W-1:0] mdata;
  } t_cci_mpf_c1Rx;

  // Count of reads in flight toward the QLP, sized for the default limit.
  typedef logic [CCI_MPF_RD_ACTIVE_CNT_W-1:0] t_cci_mpf_rd_active_cnt;

  typedef enum logic [1:0] {
    CCI_MPF_RD_ERR_NONE      = 2'd0,
    CCI_MPF_RD_ERR_OVERFLOW  = 2'd1,
    CCI_MPF_RD_ERR_UNDERFLOW = 2'd2
  } t_cci_mpf_rd_err;

  // Bits needed to hold the values 0..maxVal inclusive.
  function automatic int cci_mpf_cnt_bits(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/cci_mpf_if.sv
// CCI-MPF channel bundle between the AFU, shims and the QLP.
interface cci_mpf_if;
  import cci_mpf_if_pkg::*;

  // Channel handshake: a request is transferred in every cycle its *Valid bit
  // is 1; there is no ready. Back-pressure is advisory via *AlmFull, and the
  // sender may still issue a bounded number of requests after seeing it.
  logic               reset_n;
  logic               C0TxRdValid;
  t_cci_mpf_ReqMemHdr C0TxHdr;
  logic               c0TxAlmFull;
  t_cci_mpf_c1Tx      c1Tx;
  logic               c1TxAlmFull;
  t_cci_mpf_c0Rx      c0Rx;
  t_cci_mpf_c1Rx      c1Rx;

  // A shim drives requests toward the QLP and receives flow control/responses.
  modport to_qlp (
    output C0TxRdValid, C0TxHdr, c1Tx,
    input  c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
  );

  // A shim serves the AFU: it drives reset, flow control and responses.
  modport to_afu (
    output reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
    input  C0TxRdValid, C0TxHdr, c1Tx
  );

endinterface

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small FIFO with a combinational head read (LUT-RAM style storage).
// The caller must not enqueue when full unless it dequeues in the same cycle.
module cci_mpf_prim_fifo_lutram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             enqData,
  input  logic                         enqEn,
  output logic                         notFull,
  output logic [WIDTH-1:0]             first,
  input  logic                         deqEn,
  output logic                         notEmpty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (enqEn) begin
      mem[wrPtr] <= enqData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (enqEn) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (deqEn) begin
        rdPtr <= nextPtr(rdPtr);
      end
      if (enqEn && !deqEn) begin
        count <= count + CNT_W'(1);
      end else if (deqEn && !enqEn) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign first    = mem[rdPtr];
  assign notEmpty = (count != '0);
  assign notFull  = (int'(count) != DEPTH);

endmodule

// File: rtl/cci_mpf_shim_rd_throttle.sv
// Read throttle shim: buffers AFU C0 read requests and limits the number of
// reads in flight toward the QLP. Everything except C0 Tx passes straight through.
module cci_mpf_shim_rd_throttle
  import cci_mpf_if_pkg::*;
#(
  parameter int MAX_ACTIVE_READS = 128,
  parameter int BUF_DEPTH        = 4,
  parameter int ALM_FULL_SLACK   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  cci_mpf_if.to_qlp                             qlp,
  cci_mpf_if.to_afu                             afu,
  output logic [$clog2(MAX_ACTIVE_READS+1)-1:0] rd_active,
  output logic                                  err_overflow,
  output logic                                  err_underflow
);

  localparam int ACTIVE_W = cci_mpf_cnt_bits(MAX_ACTIVE_READS);
  localparam int HDR_W    = $bits(t_cci_mpf_ReqMemHdr);
  localparam int CNT_W    = cci_mpf_cnt_bits(BUF_DEPTH);

  // Almost-full asserts early enough that ALM_FULL_SLACK more requests still fit.
  localparam int FIFO_ALM_THRESH   = BUF_DEPTH - ALM_FULL_SLACK;
  localparam int ACTIVE_ALM_THRESH = MAX_ACTIVE_READS - ALM_FULL_SLACK;

  logic [CNT_W-1:0]    fifoCount;
  logic                fifoNotEmpty;
  logic                fifoNotFull;
  logic [HDR_W-1:0]    fifoFirst;
  logic                doIssue;
  logic                doEnq;
  logic                rspValid;
  logic                almFullNext;

  logic [ACTIVE_W-1:0] rdActiveReg;
  logic                qlpRdValidReg;
  t_cci_mpf_ReqMemHdr  qlpHdrReg;
  logic                almFullReg;
  logic                errOverflowReg;
  logic                errUnderflowReg;

  // Pass-through paths.
  assign afu.reset_n     = reset_n;
  assign qlp.c1Tx        = afu.c1Tx;
  assign afu.c1TxAlmFull = qlp.c1TxAlmFull;
  assign afu.c0Rx        = qlp.c0Rx;
  assign afu.c1Rx        = qlp.c1Rx;

  assign rspValid = qlp.c0Rx.rdValid;

  assign doIssue = fifoNotEmpty && !qlp.c0TxAlmFull &&
                   (int'(rdActiveReg) < MAX_ACTIVE_READS);

  // A full buffer can still accept a request if the head leaves this cycle.
  assign doEnq = afu.C0TxRdValid && (fifoNotFull || doIssue);

  assign almFullNext = (int'(fifoCount) >= FIFO_ALM_THRESH) ||
                       qlp.c0TxAlmFull ||
                       (int'(rdActiveReg) >= ACTIVE_ALM_THRESH);

  cci_mpf_prim_fifo_lutram #(
    .WIDTH (HDR_W),
    .DEPTH (BUF_DEPTH)
  ) reqFifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enqData  (afu.C0TxHdr),
    .enqEn    (doEnq),
    .notFull  (fifoNotFull),
    .first    (fifoFirst),
    .deqEn    (doIssue),
    .notEmpty (fifoNotEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qlpRdValidReg <= 1'b0;
      qlpHdrReg     <= '0;
    end else begin
      qlpRdValidReg <= doIssue;
      if (doIssue) begin
        qlpHdrReg <= t_cci_mpf_ReqMemHdr'(fifoFirst);
      end
    end
  end

  // Issue and response in the same cycle cancel; a stray response never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdActiveReg <= '0;
    end else if (doIssue && !rspValid) begin
      rdActiveReg <= rdActiveReg + ACTIVE_W'(1);
    end else if (rspValid && !doIssue && (rdActiveReg != '0)) begin
      rdActiveReg <= rdActiveReg - ACTIVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almFullReg      <= 1'b1;
      errOverflowReg  <= 1'b0;
      errUnderflowReg <= 1'b0;
    end else begin
      almFullReg      <= almFullNext;
      errOverflowReg  <= afu.C0TxRdValid && !fifoNotFull && !doIssue;
      errUnderflowReg <= rspValid && (rdActiveReg == '0);
    end
  end

  assign qlp.C0TxRdValid = qlpRdValidReg;
  assign qlp.C0TxHdr     = qlpHdrReg;
  assign afu.c0TxAlmFull = almFullReg;
  assign rd_active       = rdActiveReg;
  assign err_overflow    = errOverflowReg;
  assign err_underflow   = errUnderflowReg;

endmodule

// File: tb/tb_cci_mpf_shim_rd_throttle.sv
// Bench for the read throttle shim: directed scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_cci_mpf_shim_rd_throttle;
  import cci_mpf_if_pkg::*;

  localparam int MAX_RD = 4;
  localparam int BUF    = 4;
  localparam int SLACK  = 2;
  localparam int AW     = $clog2(MAX_RD + 1);
  localparam int HW     = $bits(t_cci_mpf_ReqMemHdr);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_active;
  logic          err_overflow;
  logic          err_underflow;

  cci_mpf_if qlp_bus();
  cci_mpf_if afu_bus();

  assign qlp_bus.reset_n = rst_n;

  cci_mpf_shim_rd_throttle #(
    .MAX_ACTIVE_READS (MAX_RD),
    .BUF_DEPTH        (BUF),
    .ALM_FULL_SLACK   (SLACK)
  ) dut (
    .clk           (clk),
    .reset_n       (rst_n),
    .qlp           (qlp_bus),
    .afu           (afu_bus),
    .rd_active     (rd_active),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // exp_q holds the headers buffered in the shim, oldest first.
  logic [HW-1:0] exp_q[$];
  int            m_active = 0;
  logic          m_valid  = 1'b0;
  logic [HW-1:0] m_hdr    = '0;
  logic          m_alm    = 1'b1;
  logic          m_ovf    = 1'b0;
  logic          m_unf    = 1'b0;
  bit            mi_issue;
  bit            mi_rsp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_active = 0;
      m_valid  = 1'b0;
      m_alm    = 1'b1;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      mi_issue = (exp_q.size() > 0) && !qlp_bus.c0TxAlmFull && (m_active < MAX_RD);
      mi_rsp   = qlp_bus.c0Rx.rdValid;
      m_alm    = (exp_q.size() >= BUF - SLACK) || qlp_bus.c0TxAlmFull ||
                 (m_active >= MAX_RD - SLACK);
      m_ovf    = afu_bus.C0TxRdValid && (exp_q.size() == BUF) && !mi_issue;
      m_unf    = mi_rsp && (m_active == 0);
      m_valid  = mi_issue;
      if (mi_issue) m_hdr = exp_q.pop_front();
      if (afu_bus.C0TxRdValid && !m_ovf) exp_q.push_back(afu_bus.C0TxHdr);
      m_active = m_active + (mi_issue ? 1 : 0) - ((mi_rsp && m_active > 0) ? 1 : 0);
      if (mi_issue && mi_rsp && m_active > 0 && m_active <= MAX_RD) m_active = m_active;
    end
  end

  // ---------------- compare process ----------------
  logic [HW-1:0] issued_hdr[$];
  int            issued_cyc[$];
  int            ovf_cnt = 0;
  int            unf_cnt = 0;

  always @(posedge clk) begin
    #1;
    check("rd_active", rd_active, m_active);
    check("qlp_valid", qlp_bus.C0TxRdValid, m_valid);
    if (m_valid) check("qlp_hdr", qlp_bus.C0TxHdr, m_hdr);
    check("afu_almfull", afu_bus.c0TxAlmFull, m_alm);
    check("err_overflow", err_overflow, m_ovf);
    check("err_underflow", err_underflow, m_unf);
    check("pass_reset_n", afu_bus.reset_n, qlp_bus.reset_n);
    check("pass_c0Rx", afu_bus.c0Rx, qlp_bus.c0Rx);
    check("pass_c1Rx", afu_bus.c1Rx, qlp_bus.c1Rx);
    check("pass_c1Tx", qlp_bus.c1Tx, afu_bus.c1Tx);
    check("pass_c1AlmFull", afu_bus.c1TxAlmFull, qlp_bus.c1TxAlmFull);
    if (qlp_bus.C0TxRdValid) begin
      issued_hdr.push_back(qlp_bus.C0TxHdr);
      issued_cyc.push_back(cyc);
    end
    if (err_overflow)  ovf_cnt++;
    if (err_underflow) unf_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_read(input logic [41:0] addr, input logic [15:0] mdata);
    afu_bus.C0TxHdr.addr  = addr;
    afu_bus.C0TxHdr.mdata = mdata;
    afu_bus.C0TxRdValid   = 1'b1;
    @(negedge clk);
    afu_bus.C0TxRdValid   = 1'b0;
  endtask

  task automatic send_rsp();
    qlp_bus.c0Rx.rdValid = 1'b1;
    qlp_bus.c0Rx.mdata   = 16'($urandom);
    @(negedge clk);
    qlp_bus.c0Rx.rdValid = 1'b0;
  endtask

  task automatic clear_log();
    issued_hdr.delete();
    issued_cyc.delete();
  endtask

  task automatic check_mdata(input string name, input int idx, input logic [15:0] exp);
    t_cci_mpf_ReqMemHdr h;
    if (idx < issued_hdr.size()) begin
      h = issued_hdr[idx];
      check(name, h.mdata, exp);
    end else begin
      check(name, 16'hFFFF, exp ^ 16'hFFFF ^ 16'hFFFF ^ 16'h1) ;
    end
  endtask

  function automatic logic [41:0] rnd_addr();
    return 42'({$urandom, $urandom});
  endfunction

  // ---------------- stimulus ----------------
  int c_a;
  int u0;
  int o0;
  int guard;
  t_cci_mpf_ReqMemHdr h0;

  initial begin
    afu_bus.C0TxRdValid     = 1'b0;
    afu_bus.C0TxHdr         = '0;
    afu_bus.c1Tx            = '0;
    qlp_bus.c0TxAlmFull     = 1'b0;
    qlp_bus.c1TxAlmFull     = 1'b0;
    qlp_bus.c0Rx            = '0;
    qlp_bus.c1Rx            = '0;

    // Reset state
    idle(3);
    check("rst_rd_active", rd_active, 0);
    check("rst_qlp_valid", qlp_bus.C0TxRdValid, 0);
    check("rst_almfull", afu_bus.c0TxAlmFull, 1);
    check("rst_err_ovf", err_overflow, 0);
    check("rst_err_unf", err_underflow, 0);
    check("rst_afu_reset_n", afu_bus.reset_n, 0);
    #2 rst_n = 1'b1;
    idle(3);
    check("post_rst_almfull", afu_bus.c0TxAlmFull, 0);

    // One read, latency and bit-exact header
    clear_log();
    c_a = cyc;
    send_read(42'h123456789, 16'hABC);
    idle(5);
    check("s1_issue_count", issued_hdr.size(), 1);
    if (issued_hdr.size() >= 1) begin
      h0 = issued_hdr[0];
      check("s1_latency", issued_cyc[0] - c_a, 2);
      check("s1_mdata", h0.mdata, 16'hABC);
      check("s1_addr", h0.addr, 42'h123456789);
    end
    check("s1_rd_active_1", rd_active, 1);
    send_rsp();
    idle(2);
    check("s1_rd_active_0", rd_active, 0);

    // Eight back-to-back reads against a limit of four
    clear_log();
    for (int i = 0; i < 8; i++) send_read(rnd_addr(), 16'(16'h200 + i));
    idle(6);
    check("s2_issued_before_rsp", issued_hdr.size(), 4);
    check("s2_rd_active_max", rd_active, 4);
    check("s2_almfull", afu_bus.c0TxAlmFull, 1);
    for (int i = 0; i < 4; i++) begin
      send_rsp();
      idle(4);
      check("s2_issue_per_rsp", issued_hdr.size(), 5 + i);
    end
    for (int i = 0; i < 8; i++) check_mdata("s2_order", i, 16'(16'h200 + i));
    repeat (4) send_rsp();
    idle(3);
    check("s2_drained", rd_active, 0);

    // QLP almost-full hold with two reads pending
    clear_log();
    qlp_bus.c0TxAlmFull = 1'b1;
    send_read(rnd_addr(), 16'h300);
    send_read(rnd_addr(), 16'h301);
    idle(8);
    check("s3_no_issue_during_hold", issued_hdr.size(), 0);
    qlp_bus.c0TxAlmFull = 1'b0;
    idle(4);
    check("s3_issue_count", issued_hdr.size(), 2);
    if (issued_hdr.size() == 2) check("s3_consecutive", issued_cyc[1] - issued_cyc[0], 1);
    check_mdata("s3_order0", 0, 16'h300);
    check_mdata("s3_order1", 1, 16'h301);
    repeat (2) send_rsp();
    idle(2);
    check("s3_drained", rd_active, 0);

    // Issue and response in the same cycle at rd_active=3
    clear_log();
    for (int i = 0; i < 3; i++) send_read(rnd_addr(), 16'(16'h400 + i));
    idle(4);
    check("s4_rd_active_3", rd_active, 3);
    qlp_bus.c0TxAlmFull = 1'b1;
    send_read(rnd_addr(), 16'h403);
    idle(3);
    check("s4_pending_held", issued_hdr.size(), 3);
    qlp_bus.c0TxAlmFull = 1'b0;
    send_rsp();
    check("s4_same_cycle_rd_active", rd_active, 3);
    check("s4_issued_4", issued_hdr.size(), 4);
    check_mdata("s4_last_mdata", 3, 16'h403);
    idle(2);
    check("s4_rd_active_stable", rd_active, 3);
    repeat (3) send_rsp();
    idle(2);
    check("s4_drained", rd_active, 0);

    // Reset mid-flight, then stray responses
    clear_log();
    for (int i = 0; i < 3; i++) send_read(rnd_addr(), 16'(16'h500 + i));
    idle(4);
    check("s5_rd_active_3", rd_active, 3);
    u0 = unf_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_rd_active", rd_active, 0);
    check("s5_async_qlp_valid", qlp_bus.C0TxRdValid, 0);
    check("s5_async_almfull", afu_bus.c0TxAlmFull, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send_rsp();
      idle(2);
    end
    check("s5_unf_pulses", unf_cnt - u0, 3);
    check("s5_rd_active_0", rd_active, 0);

    // Five reads into a four-deep buffer with the QLP stalled
    clear_log();
    o0 = ovf_cnt;
    qlp_bus.c0TxAlmFull = 1'b1;
    for (int i = 0; i < 5; i++) send_read(rnd_addr(), 16'(16'h600 + i));
    idle(4);
    check("s6_ovf_pulses", ovf_cnt - o0, 1);
    check("s6_held", issued_hdr.size(), 0);
    qlp_bus.c0TxAlmFull = 1'b0;
    idle(8);
    check("s6_issue_count", issued_hdr.size(), 4);
    for (int i = 0; i < 4; i++) check_mdata("s6_order", i, 16'(16'h600 + i));
    repeat (4) send_rsp();
    idle(3);
    check("s6_drained", rd_active, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      afu_bus.C0TxHdr.addr  = rnd_addr();
      afu_bus.C0TxHdr.mdata = 16'($urandom);
      afu_bus.C0TxRdValid   = ($urandom_range(0, 99) < 55);
      qlp_bus.c0TxAlmFull   = ($urandom_range(0, 99) < 20);
      qlp_bus.c1TxAlmFull   = ($urandom_range(0, 1) == 1);
      qlp_bus.c0Rx.rdValid  = ($urandom_range(0, 99) < 35);
      qlp_bus.c0Rx.mdata    = 16'($urandom);
      qlp_bus.c0Rx.data     = {$urandom, $urandom};
      qlp_bus.c1Rx.wrValid  = ($urandom_range(0, 1) == 1);
      qlp_bus.c1Rx.mdata    = 16'($urandom);
      afu_bus.c1Tx.wrValid  = ($urandom_range(0, 1) == 1);
      afu_bus.c1Tx.hdr      = {rnd_addr(), 16'($urandom)};
      afu_bus.c1Tx.data     = {$urandom, $urandom};
      @(negedge clk);
    end
    afu_bus.C0TxRdValid  = 1'b0;
    qlp_bus.c0TxAlmFull  = 1'b0;
    qlp_bus.c0Rx.rdValid = 1'b0;
    guard = 0;
    while ((m_active > 0 || exp_q.size() > 0) && guard < 200) begin
      send_rsp();
      idle(1);
      guard++;
    end
    idle(2);
    check("rand_drained_rd_active", rd_active, 0);
    check("rand_drained_qlp_valid", qlp_bus.C0TxRdValid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
